// File: rtl/instr_mem_pipe_pkg.sv
// Shared constants for the instruction-memory fetch pipe.
//   DATA_BUS_BITS  : default byte-address width coming from the PC
//   INSTR_BUS_BITS : default instruction word width
//   INSTR_NOP      : addi x0,x0,0; used for the post-reset fill and fault responses
//   IMEM_DEPTH     : default number of instruction words
//   ST_INIT/ST_RUN : FSM encodings of the fetch-pipe controller
package instr_mem_pipe_pkg;

  localparam int          DATA_BUS_BITS  = 32;
  localparam int          INSTR_BUS_BITS = 32;
  localparam logic [31:0] INSTR_NOP      = 32'h00000013;
  localparam int          IMEM_DEPTH     = 4096;

  localparam logic [0:0]  ST_INIT = 1'b0;
  localparam logic [0:0]  ST_RUN  = 1'b1;

  // Instruction fetches and loads must be word aligned.
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x W synchronous read-first RAM, one read port and one write port.
// Written so that synthesis maps it onto block RAM; it has no reset.
//   clk   : rising-edge clock
//   re    : read enable; rdata is updated at the edge only when set, otherwise it holds
//   raddr : read word index
//   rdata : registered read data (old contents on a same-edge write to the same word)
//   we    : write enable
//   waddr : write word index
//   wdata : write data
module imem_ram
  import instr_mem_pipe_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int W     = INSTR_BUS_BITS,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata
);

  logic [W-1:0] mem [DEPTH];

  // Both non-blocking, so a collision returns the pre-write word.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/instr_mem_pipe.sv
// Fetch-stage instruction memory: registered read behind valid/ready handshakes,
// single-entry response hold, flush, fault reporting, program-load port and a
// post-reset NOP fill.
//   clk, rst_n                  : clock, synchronous active-low reset
//   req_valid/req_ready/req_addr : fetch request (byte address)
//   resp_valid/resp_ready        : response handshake
//   resp_instr/resp_fault        : fetched word / misaligned-or-out-of-range flag
//   flush                        : drop held response, refuse same-cycle request
//   load_en/load_addr/load_data  : program-load write (byte address)
//   init_done                    : fill finished, memory usable
//
// state | meaning
// INIT  | writing NOP_WORD into every word, one per cycle; fetch and load blocked
// RUN   | normal fetch/load operation
module instr_mem_pipe
  import instr_mem_pipe_pkg::*;
#(
  parameter int                 ADDR_W   = DATA_BUS_BITS,
  parameter int                 INSTR_W  = INSTR_BUS_BITS,
  parameter int                 DEPTH    = IMEM_DEPTH,
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_NOP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [INSTR_W-1:0] resp_instr,
  output logic               resp_fault,
  input  logic               flush,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic               init_done
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [0:0]         state_q;
  logic [IDX_W-1:0]   cnt_q;
  logic               rd_ok_q;
  logic               accept;
  logic               req_fault;
  logic               load_fault;
  logic               ram_we;
  logic [IDX_W-1:0]   ram_waddr;
  logic [INSTR_W-1:0] ram_wdata;
  logic [INSTR_W-1:0] ram_rdata;

  // Any set bit above the word index means the address lies past the array.
  assign req_fault  = misaligned(req_addr[1:0])  || (req_addr[ADDR_W-1:IDX_W+2] != '0);
  assign load_fault = misaligned(load_addr[1:0]) || (load_addr[ADDR_W-1:IDX_W+2] != '0);

  assign init_done = (state_q == ST_RUN);
  assign req_ready = init_done && !flush && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;

  // The fill owns the write port during INIT; loads are only honoured in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = load_addr[IDX_W+1:2];
    ram_wdata = load_data;
    if (state_q == ST_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = cnt_q;
      ram_wdata = NOP_WORD;
    end else if (load_en && !load_fault) begin
      ram_we    = 1'b1;
    end
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_ram (
    .clk   (clk),
    .re    (accept && !req_fault),
    .raddr (req_addr[IDX_W+1:2]),
    .rdata (ram_rdata),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      if (state_q == ST_INIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) state_q <= ST_RUN;
      end

      if (flush)           resp_valid <= 1'b0;
      else if (accept)     resp_valid <= 1'b1;
      else if (resp_ready) resp_valid <= 1'b0;

      if (accept) begin
        resp_fault <= req_fault;
        if (!req_fault) rd_ok_q <= 1'b1;
      end
    end
  end

  // The RAM output register has no reset, so it is masked until a real read
  // has landed; a faulting response overrides it with NOP without reading.
  assign resp_instr = resp_fault ? NOP_WORD : (rd_ok_q ? ram_rdata : '0);

endmodule

// File: tb/tb_instr_mem_pipe.sv
module tb_instr_mem_pipe;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] W8  = 32'h00500093;
  localparam logic [31:0] WC  = 32'h00A00113;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic        resp_fault;
  logic        flush;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        init_done;

  int checks   = 0;
  int failures = 0;

  instr_mem_pipe #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .DEPTH    (16),
    .NOP_WORD (32'h00000013)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_instr (resp_instr),
    .resp_fault (resp_fault),
    .flush      (flush),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and registered outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_addr = 32'h0; resp_ready = 1'b1;
    flush = 1'b0; load_en = 1'b0; load_addr = 32'h0; load_data = 32'h0;
    tick();
    tick();
    #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_instr !== 32'h0) begin failures++; $display("FAIL reset_resp_instr got=%h exp=00000000", resp_instr); end
    checks++; if (resp_fault !== 1'b0) begin failures++; $display("FAIL reset_resp_fault got=%b exp=0", resp_fault); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
  endtask

  task automatic test_fill();
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i < 16) begin
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL fill_req_ready cyc=%0d got=%b exp=0", i, req_ready); end
      end
      tick();
      checks++;
      if (init_done !== (i == 16)) begin
        failures++; $display("FAIL fill_init_done cyc=%0d got=%b exp=%b", i, init_done, (i == 16));
      end
    end
    for (int a = 0; a < 16; a++) begin
      req_valid = 1'b1; req_addr = 32'(a * 4);
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL fill_fetch_ready addr=%h got=%b exp=1", req_addr, req_ready); end
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_instr !== NOP || resp_fault !== 1'b0) begin
        failures++; $display("FAIL fill_fetch addr=%h got v=%b i=%h f=%b exp v=1 i=%h f=0",
                             32'(a * 4), resp_valid, resp_instr, resp_fault, NOP);
      end
    end
    req_valid = 1'b0;
    tick();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL fill_drain got=%b exp=0", resp_valid); end
  endtask

  task automatic test_load_fetch();
    load_en = 1'b1; load_addr = 32'h8; load_data = W8;
    tick();
    load_addr = 32'hC; load_data = WC;
    tick();
    load_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'h8; resp_ready = 1'b1;
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_instr !== W8) begin failures++; $display("FAIL lf_first got v=%b i=%h exp v=1 i=%h", resp_valid, resp_instr, W8); end
    req_addr = 32'hC;
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_instr !== WC) begin failures++; $display("FAIL lf_second got v=%b i=%h exp v=1 i=%h", resp_valid, resp_instr, WC); end
    req_valid = 1'b0;
    tick();
    checks++; if (resp_valid !== 1'b0 || resp_instr !== WC) begin failures++; $display("FAIL lf_consumed got v=%b i=%h exp v=0 i=%h", resp_valid, resp_instr, WC); end
  endtask

  task automatic test_stall();
    req_valid = 1'b1; req_addr = 32'h8; resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0; req_addr = 32'hC;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", i, req_ready); end
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_instr !== W8) begin
        failures++; $display("FAIL stall_hold cyc=%0d got v=%b i=%h exp v=1 i=%h", i, resp_valid, resp_instr, W8);
      end
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%b exp=1", req_ready); end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_instr !== WC) begin failures++; $display("FAIL stall_next got v=%b i=%h exp v=1 i=%h", resp_valid, resp_instr, WC); end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_faults();
    resp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h6;
    tick();
    checks++; if (resp_fault !== 1'b1 || resp_instr !== NOP) begin failures++; $display("FAIL fault_misaligned got f=%b i=%h exp f=1 i=%h", resp_fault, resp_instr, NOP); end
    req_addr = 32'h40;
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_instr !== NOP) begin failures++; $display("FAIL fault_range got v=%b f=%b i=%h exp v=1 f=1 i=%h", resp_valid, resp_fault, resp_instr, NOP); end
    req_valid = 1'b0;
    load_en = 1'b1; load_addr = 32'h6; load_data = 32'hFFFFFFFF;
    tick();
    load_addr = 32'h48; load_data = 32'h11111111;
    tick();
    load_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'h4;
    tick();
    checks++; if (resp_fault !== 1'b0 || resp_instr !== NOP) begin failures++; $display("FAIL fault_load_misaligned got f=%b i=%h exp f=0 i=%h", resp_fault, resp_instr, NOP); end
    req_addr = 32'h8;
    tick();
    checks++; if (resp_fault !== 1'b0 || resp_instr !== W8) begin failures++; $display("FAIL fault_load_range got f=%b i=%h exp f=0 i=%h", resp_fault, resp_instr, W8); end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush_collision();
    req_valid = 1'b1; req_addr = 32'h8; resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0; flush = 1'b1; req_addr = 32'hC;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL flush_stalled_ready got=%b exp=0", req_ready); end
    tick();
    flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL flush_drop got=%b exp=0", resp_valid); end
    flush = 1'b1; req_valid = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL flush_idle_ready got=%b exp=0", req_ready); end
    tick();
    flush = 1'b0; req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL flush_no_accept got=%b exp=0", resp_valid); end
    req_valid = 1'b1; req_addr = 32'h8;
    load_en = 1'b1; load_addr = 32'h8; load_data = 32'hDEADBEEF;
    tick();
    load_en = 1'b0;
    checks++; if (resp_instr !== W8) begin failures++; $display("FAIL collision_old got=%h exp=%h", resp_instr, W8); end
    tick();
    checks++; if (resp_instr !== 32'hDEADBEEF) begin failures++; $display("FAIL collision_new got=%h exp=deadbeef", resp_instr); end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    int n;
    req_valid = 1'b1; req_addr = 32'hC; resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_pending got=%b exp=1", resp_valid); end
    rst_n = 1'b0;
    tick();
    checks++;
    if (resp_valid !== 1'b0 || init_done !== 1'b0 || resp_instr !== 32'h0 || req_ready !== 1'b0) begin
      failures++; $display("FAIL rst_mid_state got v=%b d=%b i=%h r=%b exp v=0 d=0 i=00000000 r=0",
                           resp_valid, init_done, resp_instr, req_ready);
    end
    rst_n = 1'b1; resp_ready = 1'b1;
    n = 0;
    while (init_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n != 16) begin failures++; $display("FAIL rst_mid_refill_cycles got=%0d exp=16", n); end
    req_valid = 1'b1; req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_instr !== NOP) begin failures++; $display("FAIL rst_mid_refetch got v=%b i=%h exp v=1 i=%h", resp_valid, resp_instr, NOP); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_load_fetch();
    test_stall();
    test_faults();
    test_flush_collision();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
